// File: rtl/cdb_arbiter.sv
// Result broadcast (CDB) arbiter: one holding slot per functional unit, round-robin
// grant of one result per cycle onto a registered wakeup/forwarding bus.
module cdb_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 32,
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W = $clog2(NREQ + 1)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     STALL,
    input  logic                     FLUSH,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*TAG_W-1:0]    req_map,
    input  logic [NREQ*DATA_W-1:0]   req_val,
    input  logic [NREQ*NUM_W-1:0]    req_num,
    output logic [NREQ-1:0]          req_ready,
    output logic                     exe_broadcast,
    output logic [TAG_W-1:0]         exe_broadcast_map,
    output logic [DATA_W-1:0]        exe_broadcast_val,
    output logic [NUM_W-1:0]         broadcast_instr_num,
    output logic [CNT_W-1:0]         pending
);

    logic [NREQ-1:0]              slot_v_q,   slot_v_d;
    logic [NREQ-1:0][TAG_W-1:0]   slot_map_q, slot_map_d;
    logic [NREQ-1:0][DATA_W-1:0]  slot_val_q, slot_val_d;
    logic [NREQ-1:0][NUM_W-1:0]   slot_num_q, slot_num_d;
    logic [PTR_W-1:0]             rr_ptr_q,   rr_ptr_d;
    logic                         bc_v_q,     bc_v_d;
    logic [TAG_W-1:0]             bc_map_q,   bc_map_d;
    logic [DATA_W-1:0]            bc_val_q,   bc_val_d;
    logic [NUM_W-1:0]             bc_num_q,   bc_num_d;

    logic [NREQ-1:0]              elig_s;
    logic [NREQ-1:0]              drop_s;
    logic [NREQ-1:0]              grant_s;
    logic [NREQ-1:0]              accept_s;
    logic                         grant_any_s;
    logic [PTR_W-1:0]             grant_idx_s;
    logic [PTR_W:0]               pick_s;

    // First set bit of elig at or above ptr, wrapping modulo NREQ; MSB flags a hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] elig,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        logic [PTR_W:0] sum;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ)) begin
                sum = sum - (PTR_W+1)'(NREQ);
            end else begin
                sum = sum;
            end
            if (elig[sum[PTR_W-1:0]]) begin
                res = {1'b1, sum[PTR_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NREQ-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NREQ; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Slot classification, round-robin grant and the ready/accept handshake.
    always_comb begin
        elig_s      = '0;
        drop_s      = '0;
        grant_s     = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = slot_v_q[i] & (slot_map_q[i] != '0);
            drop_s[i] = slot_v_q[i] & (slot_map_q[i] == '0);
        end
        pick_s      = rr_pick(elig_s, rr_ptr_q);
        grant_any_s = pick_s[PTR_W];
        grant_idx_s = pick_s[PTR_W-1:0];
        for (int i = 0; i < NREQ; i++) begin
            grant_s[i] = grant_any_s & (grant_idx_s == PTR_W'(i));
        end
        // Ready never looks at req_valid, so requesters can't form a loop through it.
        req_ready = {NREQ{RESET & ~STALL & ~FLUSH}} & (~slot_v_q | grant_s | drop_s);
        accept_s  = req_valid & req_ready;
    end

    // Next-state for slots, pointer and broadcast registers; FLUSH beats STALL.
    always_comb begin
        slot_v_d   = slot_v_q;
        slot_map_d = slot_map_q;
        slot_val_d = slot_val_q;
        slot_num_d = slot_num_q;
        rr_ptr_d   = rr_ptr_q;
        bc_v_d     = bc_v_q;
        bc_map_d   = bc_map_q;
        bc_val_d   = bc_val_q;
        bc_num_d   = bc_num_q;
        if (FLUSH) begin
            slot_v_d = '0;
            rr_ptr_d = '0;
            bc_v_d   = 1'b0;
            bc_map_d = '0;
            bc_val_d = '0;
            bc_num_d = '0;
        end else if (STALL) begin
            slot_v_d = slot_v_q;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // A reload wins over the clear from a same-edge grant or drop.
                if (accept_s[i]) begin
                    slot_v_d[i]   = 1'b1;
                    slot_map_d[i] = req_map[i*TAG_W +: TAG_W];
                    slot_val_d[i] = req_val[i*DATA_W +: DATA_W];
                    slot_num_d[i] = req_num[i*NUM_W +: NUM_W];
                end else if (grant_s[i] | drop_s[i]) begin
                    slot_v_d[i] = 1'b0;
                end else begin
                    slot_v_d[i] = slot_v_q[i];
                end
            end
            if (grant_any_s) begin
                bc_v_d   = 1'b1;
                bc_map_d = slot_map_q[grant_idx_s];
                bc_val_d = slot_val_q[grant_idx_s];
                bc_num_d = slot_num_q[grant_idx_s];
                if (grant_idx_s == PTR_W'(NREQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx_s + PTR_W'(1);
                end
            end else begin
                bc_v_d   = 1'b0;
                bc_map_d = '0;
                bc_val_d = '0;
                bc_num_d = '0;
                rr_ptr_d = rr_ptr_q;
            end
        end
    end

    // State and broadcast registers; RESET discards everything asynchronously.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot_v_q   <= '0;
            slot_map_q <= '0;
            slot_val_q <= '0;
            slot_num_q <= '0;
            rr_ptr_q   <= '0;
            bc_v_q     <= 1'b0;
            bc_map_q   <= '0;
            bc_val_q   <= '0;
            bc_num_q   <= '0;
        end else begin
            slot_v_q   <= slot_v_d;
            slot_map_q <= slot_map_d;
            slot_val_q <= slot_val_d;
            slot_num_q <= slot_num_d;
            rr_ptr_q   <= rr_ptr_d;
            bc_v_q     <= bc_v_d;
            bc_map_q   <= bc_map_d;
            bc_val_q   <= bc_val_d;
            bc_num_q   <= bc_num_d;
        end
    end

    assign exe_broadcast       = bc_v_q;
    assign exe_broadcast_map   = bc_map_q;
    assign exe_broadcast_val   = bc_val_q;
    assign broadcast_instr_num = bc_num_q;
    assign pending             = popcount(slot_v_q);

endmodule
